// File: rtl/dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dcm_reset_sequencer
// Description : Supervises NUM_DCM clock managers. Holds them in reset, waits
//               for all of them to lock, requires a stable lock interval and
//               then releases the per-domain logic resets one at a time in
//               index order. A lock loss after release restarts the whole
//               sequence. Repeated lock timeouts park the block in FAULT
//               until rearm is pulsed.
// Ports       : clock           - free-running reference clock
//               reset           - synchronous, active-high reset
//               locked          - per-DCM LOCKED, asynchronous to clock
//               rearm           - single-cycle request to leave FAULT
//               dcm_reset       - reset to all DCM RST pins
//               domain_reset    - per-domain logic reset, active high
//               all_locked      - high only in RUN
//               fault           - high only in FAULT
//               retry_count     - timed-out attempts since RUN entry/rearm
//               lock_loss_count - saturating lock-loss event count
//               state           - current state encoding (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_reset_sequencer #(
    parameter int NUM_DCM         = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STABLE_CYCLES   = 64,
    parameter int RELEASE_GAP     = 4,
    parameter int MAX_RETRIES     = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_DCM-1:0] locked,
    input  logic               rearm,
    output logic               dcm_reset,
    output logic [NUM_DCM-1:0] domain_reset,
    output logic               all_locked,
    output logic               fault,
    output logic [3:0]         retry_count,
    output logic [7:0]         lock_loss_count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    // Counter compare points; the counter holds the number of completed
    // cycles in the current state, so "N cycles elapsed" is cnt == N-1.
    localparam logic [19:0]        c_hold_last    = 20'(RST_HOLD_CYCLES - 1);
    localparam logic [19:0]        c_timeout_last = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0]        c_stable_last  = 20'(STABLE_CYCLES - 1);
    localparam logic [19:0]        c_release_done = 20'((NUM_DCM - 1) * RELEASE_GAP);
    localparam logic [3:0]         c_max_retries  = 4'(MAX_RETRIES);
    localparam logic [NUM_DCM-1:0] c_first_domain = NUM_DCM'(1);

    logic [NUM_DCM-1:0] r_meta;
    logic [NUM_DCM-1:0] r_sync;
    state_t             r_state;
    logic [19:0]        r_cnt;
    logic               r_dcm_reset;
    logic [NUM_DCM-1:0] r_domain_reset;
    logic               r_all_locked;
    logic               r_fault;
    logic [3:0]         r_retry;
    logic [7:0]         r_loss;

    logic               w_all_locked;
    logic [19:0]        w_cnt_inc;
    logic [NUM_DCM-1:0] w_release_mask;

    assign w_all_locked = &r_sync;
    assign w_cnt_inc    = r_cnt + 20'd1;

    // Domain i (i >= 1) is released on the edge that completes i*RELEASE_GAP
    // cycles in RELEASE; domain 0 is released on entry.
    assign w_release_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DCM; gi++) begin : g_release_mask
        assign w_release_mask[gi] = (w_cnt_inc == 20'(gi * RELEASE_GAP));
    end

    // Two-flop synchronizer for the asynchronous LOCKED inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= locked;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_HOLD;
            r_cnt          <= '0;
            r_dcm_reset    <= 1'b1;
            r_domain_reset <= '1;
            r_all_locked   <= 1'b0;
            r_fault        <= 1'b0;
            r_retry        <= '0;
            r_loss         <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_state     <= S_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_dcm_reset <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (w_all_locked) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_timeout_last) begin
                        r_cnt          <= '0;
                        r_dcm_reset    <= 1'b1;
                        r_domain_reset <= '1;
                        if (r_retry == c_max_retries) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                            r_retry <= r_retry + 4'd1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_SETTLE: begin
                    // A glitch restarts the lock wait without costing a retry.
                    if (!w_all_locked) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_stable_last) begin
                        r_state        <= S_RELEASE;
                        r_cnt          <= '0;
                        r_domain_reset <= ~c_first_domain;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_RELEASE, S_RUN: begin
                    if (!w_all_locked) begin
                        r_state        <= S_HOLD;
                        r_cnt          <= '0;
                        r_dcm_reset    <= 1'b1;
                        r_domain_reset <= '1;
                        r_all_locked   <= 1'b0;
                        if (r_loss != 8'hFF) begin
                            r_loss <= r_loss + 8'd1;
                        end
                    end else if (r_state == S_RELEASE) begin
                        if (r_cnt == c_release_done) begin
                            r_state      <= S_RUN;
                            r_cnt        <= '0;
                            r_all_locked <= 1'b1;
                            r_retry      <= '0;
                        end else begin
                            r_cnt          <= w_cnt_inc;
                            r_domain_reset <= r_domain_reset & ~w_release_mask;
                        end
                    end
                end

                S_FAULT: begin
                    if (rearm) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                        r_retry <= '0;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= S_HOLD;
                    r_cnt          <= '0;
                    r_dcm_reset    <= 1'b1;
                    r_domain_reset <= '1;
                    r_all_locked   <= 1'b0;
                    r_fault        <= 1'b0;
                end
            endcase
        end
    end

    assign dcm_reset       = r_dcm_reset;
    assign domain_reset    = r_domain_reset;
    assign all_locked      = r_all_locked;
    assign fault           = r_fault;
    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss;
    assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcm_reset_sequencer
// Description : Directed bench for dcm_reset_sequencer. A behavioural model
//               tracks the sequencer phase and time spent in it; outputs are
//               compared against it every cycle, and literal expectations
//               pin key timings (hold length, release gap, timeouts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcm_reset_sequencer;

    localparam int N     = 2;
    localparam int HOLD  = 16;
    localparam int TO    = 100;
    localparam int STAB  = 8;
    localparam int GAP   = 4;
    localparam int MAXR  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] locked = '0;
    logic         rearm = 1'b0;
    logic         dcm_reset;
    logic [N-1:0] domain_reset;
    logic         all_locked;
    logic         fault;
    logic [3:0]   retry_count;
    logic [7:0]   lock_loss_count;
    logic [2:0]   state;

    always #5 clk = ~clk;

    dcm_reset_sequencer #(
        .NUM_DCM(N), .RST_HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TO),
        .STABLE_CYCLES(STAB), .RELEASE_GAP(GAP), .MAX_RETRIES(MAXR)
    ) dut (
        .clock(clk), .reset(reset), .locked(locked), .rearm(rearm),
        .dcm_reset(dcm_reset), .domain_reset(domain_reset),
        .all_locked(all_locked), .fault(fault), .retry_count(retry_count),
        .lock_loss_count(lock_loss_count), .state(state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural model ----------------
    // phase: 0 HOLD, 1 WAIT_LOCK, 2 SETTLE, 3 RELEASE, 4 RUN, 5 FAULT
    int       m_phase = 0;
    int       m_n = 0;      // cycles completed in current phase
    int       m_retry = 0;
    int       m_loss = 0;
    logic [N-1:0] m_hist0 = '0;  // locked seen one edge ago
    logic [N-1:0] m_hist1 = '0;  // locked seen two edges ago (decision value)

    initial begin : model
        int   nxt;
        logic ok;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0; m_n = 0; m_retry = 0; m_loss = 0;
                m_hist0 = '0; m_hist1 = '0;
            end else begin
                ok  = (m_hist1 == {N{1'b1}});
                nxt = m_phase;
                case (m_phase)
                    0: if (m_n + 1 == HOLD) nxt = 1;
                    1: begin
                        if (ok) nxt = 2;
                        else if (m_n + 1 == TO) begin
                            if (m_retry == MAXR) nxt = 5;
                            else begin m_retry++; nxt = 0; end
                        end
                    end
                    2: begin
                        if (!ok) nxt = 1;
                        else if (m_n + 1 == STAB) nxt = 3;
                    end
                    3, 4: begin
                        if (!ok) begin
                            nxt = 0;
                            if (m_loss < 255) m_loss++;
                        end else if (m_phase == 3 && m_n == (N - 1) * GAP) begin
                            nxt = 4;
                            m_retry = 0;
                        end
                    end
                    5: if (rearm) begin nxt = 0; m_retry = 0; end
                    default: nxt = 0;
                endcase
                if (nxt != m_phase) m_n = 0;
                else m_n++;
                m_phase = nxt;
                m_hist1 = m_hist0;
                m_hist0 = locked;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : cmp
        logic [19:0]  e;
        logic [19:0]  a;
        logic [N-1:0] ed;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                ed[i] = (m_phase == 3) ? (m_n < i * GAP) : (m_phase != 4);
            e = {(m_phase == 0 || m_phase == 5), ed, (m_phase == 4), (m_phase == 5),
                 4'(m_retry), 8'(m_loss), 3'(m_phase)};
            a = {dcm_reset, domain_reset, all_locked, fault, retry_count,
                 lock_loss_count, state};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle_outputs @%0d: got %h expected %h", cyc, a, e);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int t);
        int k;
        k = 0;
        while (state !== s && k < max) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (state !== s) begin
            n_err++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", state, s, max);
        end
        t = cyc;
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int base, t, t1, t2, ts, ts2, tw, k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dcm_reset", 32'(dcm_reset), 1);
        check("rst_domain_reset", 32'(domain_reset), 3);
        check("rst_state", 32'(state), 0);
        check("rst_all_locked", 32'(all_locked), 0);

        // Power-up sequence: locked from cycle 20
        reset = 1'b0;
        base  = cyc;
        wait_state(3'd1, 40, t);
        check("hold_length", 32'(t - base), 16);
        while (cyc - base < 20) @(negedge clk);
        locked = 2'b11;
        wait_state(3'd3, 60, t);
        check("release_entry", 32'(t - base), 31);
        check("first_release", 32'(domain_reset), 2);
        k = 0;
        while (domain_reset == 2'b10 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("release_gap", 32'(k), 4);
        wait_state(3'd4, 10, t);
        check("run_entry", 32'(t - base), 36);
        check("run_all_locked", 32'(all_locked), 1);
        check("run_retry", 32'(retry_count), 0);
        check("run_domains", 32'(domain_reset), 0);

        // rearm outside FAULT is ignored; then a one-cycle drop of locked[1]
        pulse_rearm();
        locked = 2'b01;
        @(negedge clk);
        locked = 2'b11;
        k = 1;
        while (all_locked && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("loss_latency", 32'(k), 3);
        check("loss_domains", 32'(domain_reset), 3);
        check("loss_count_1", 32'(lock_loss_count), 1);
        wait_state(3'd4, 80, t);
        check("rerun_domains", 32'(domain_reset), 0);

        // Never lock: three attempts then FAULT
        locked = 2'b00;
        wait_state(3'd0, 10, t);
        wait_state(3'd1, 30, t1);
        wait_state(3'd0, 150, t2);
        check("timeout1_len", 32'(t2 - t1), 100);
        check("retry_1", 32'(retry_count), 1);
        wait_state(3'd1, 30, t1);
        wait_state(3'd0, 150, t2);
        check("timeout2_len", 32'(t2 - t1), 100);
        check("retry_2", 32'(retry_count), 2);
        wait_state(3'd1, 30, t1);
        wait_state(3'd5, 150, t2);
        check("timeout3_len", 32'(t2 - t1), 100);
        check("fault_flag", 32'(fault), 1);
        check("fault_dcm_reset", 32'(dcm_reset), 1);
        check("fault_retry", 32'(retry_count), 2);
        // locked is ignored in FAULT
        locked = 2'b11;
        repeat (10) @(negedge clk);
        check("fault_sticky", 32'(state), 5);
        locked = 2'b00;
        pulse_rearm();
        check("rearm_state", 32'(state), 0);
        check("rearm_retry", 32'(retry_count), 0);

        // One timeout (rearm in WAIT_LOCK ignored), then a SETTLE glitch
        wait_state(3'd1, 30, t);
        pulse_rearm();
        wait_state(3'd0, 150, t);
        check("retry_after_wait_rearm", 32'(retry_count), 1);
        locked = 2'b11;
        wait_state(3'd2, 60, ts);
        repeat (4) @(negedge clk);
        locked = 2'b10;
        @(negedge clk);
        locked = 2'b11;
        wait_state(3'd1, 10, tw);
        check("settle_abort_time", 32'(tw - ts), 7);
        check("settle_abort_retry", 32'(retry_count), 1);
        wait_state(3'd2, 10, ts2);
        wait_state(3'd3, 20, t);
        check("settle_fresh_len", 32'(t - ts2), 8);
        wait_state(3'd4, 20, t);
        check("run_retry_clear", 32'(retry_count), 0);

        // Reset pulse during RELEASE
        locked = 2'b01;
        @(negedge clk);
        locked = 2'b11;
        wait_state(3'd3, 80, t);
        check("pre_reset_domains", 32'(domain_reset), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", 32'(state), 0);
        check("midrst_dcm", 32'(dcm_reset), 1);
        check("midrst_domains", 32'(domain_reset), 3);
        check("midrst_loss", 32'(lock_loss_count), 0);

        // Saturation of the lock-loss counter
        for (int i = 0; i < 260; i++) begin
            wait_state(3'd4, 100, t);
            locked = 2'b01;
            @(negedge clk);
            locked = 2'b11;
            wait_state(3'd0, 10, t);
        end
        check("loss_saturated", 32'(lock_loss_count), 255);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcm_reset_sequencer.md
DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 SHALL provide parameter NUM_DCM, default 2, number of DCMs/clock domains supervised (legal 1..8).
REQ-002 SHALL provide parameter RST_HOLD_CYCLES, default 16, number of cycles dcm_reset is held high per attempt (legal 1..2^20-1).
REQ-003 SHALL provide parameter LOCK_TIMEOUT, default 65536, number of cycles allowed for all DCMs to lock per attempt (legal 1..2^20-1).
REQ-004 SHALL provide parameter STABLE_CYCLES, default 64, number of consecutive all-locked cycles required before releasing any domain (legal 1..2^20-1).
REQ-005 SHALL provide parameter RELEASE_GAP, default 4, number of cycles between successive domain reset releases (legal 1..255).
REQ-006 SHALL provide parameter MAX_RETRIES, default 3, number of timed-out attempts tolerated before FAULT (legal 0..15).
REQ-007 clock  input  1  free-running reference clock; all logic runs on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 locked  input  NUM_DCM  per-DCM LOCKED outputs; asynchronous to clock.
REQ-010 rearm  input  1  single-cycle request to leave FAULT.
REQ-011 dcm_reset  output  1  reset driven to all DCM RST pins.
REQ-012 domain_reset  output  NUM_DCM  per-domain logic reset, active high.
REQ-013 all_locked  output  1  high only in RUN.
REQ-014 fault  output  1  high only in FAULT.
REQ-015 retry_count  output  4  timed-out attempts since last RUN entry or rearm.
REQ-016 lock_loss_count  output  8  lock-loss events since reset, saturating at 255.
REQ-017 state  output  3  current state encoding for debug.

Function
REQ-018 SHALL pass locked through a two-flop synchronizer (locked_sync); all decisions SHALL use locked_sync only; "all locked" means every bit of locked_sync is 1.
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be HOLD=0, WAIT_LOCK=1, SETTLE=2, RELEASE=3, RUN=4, FAULT=5; one 20-bit cycle counter SHALL be cleared on every state transition.
REQ-021 HOLD: dcm_reset=1 and all domain_reset=1; after RST_HOLD_CYCLES cycles in HOLD, transition to WAIT_LOCK.
REQ-022 WAIT_LOCK: dcm_reset=0. If all locked, transition to SETTLE. Otherwise, on the LOCK_TIMEOUT-th cycle, transition to FAULT if retry_count==MAX_RETRIES; else increment retry_count and transition to HOLD. If the lock and timeout conditions occur in the same cycle, lock SHALL win.
REQ-023 SETTLE: after STABLE_CYCLES consecutive all-locked cycles, transition to RELEASE. Any locked_sync bit low SHALL transition to WAIT_LOCK with a fresh timeout and without incrementing retry_count.
REQ-024 RELEASE: domain_reset[0] SHALL deassert on the first cycle in RELEASE; domain_reset[i] SHALL deassert RELEASE_GAP cycles after domain_reset[i-1]. One cycle after domain_reset[NUM_DCM-1] deasserts, transition to RUN.
REQ-025 RUN: all_locked=1; retry_count SHALL clear to 0 on entry.
REQ-026 Any locked_sync bit low in RELEASE or RUN SHALL: assert all domain_reset bits and deassert all_locked on the next edge; increment lock_loss_count (saturating); transition to HOLD.
REQ-027 FAULT: dcm_reset=1, all domain_reset=1, fault=1; locked is ignored. rearm SHALL clear retry_count and transition to HOLD. rearm outside FAULT SHALL be ignored.
REQ-028 Domain releases SHALL occur in index order only; a released domain SHALL NOT be re-asserted except per REQ-026, REQ-029 or FAULT entry.

Reset
REQ-029 While reset=1, on each clock edge: state=HOLD, counter=0, synchronizer flops=0, dcm_reset=1, domain_reset all 1s, all_locked=0, fault=0, retry_count=0, lock_loss_count=0. Reset SHALL take priority over all other inputs, including mid-operation and in FAULT.
REQ-030 The first HOLD interval after reset deasserts SHALL last exactly RST_HOLD_CYCLES cycles.

Verification
REQ-031 Use NUM_DCM=2, RST_HOLD_CYCLES=16, LOCK_TIMEOUT=100, STABLE_CYCLES=8, RELEASE_GAP=4, MAX_RETRIES=2.
REQ-032 Release reset; locked=2'b11 from cycle 20 -> dcm_reset low after exactly 16 cycles; domain_reset 11->10->00 with a 4-cycle gap; then all_locked=1 and retry_count=0.
REQ-033 Hold locked=2'b00 -> three 100-cycle WAIT_LOCK attempts, retry_count 0->1->2, then fault=1, dcm_reset=1, state=5; pulse rearm -> state=0, retry_count=0.
REQ-034 In RUN, drop locked[1] for 1 cycle -> domain_reset=2'b11 and all_locked=0 within 3 cycles; lock_loss_count=1; full sequence repeats once locked returns.
REQ-035 In SETTLE, drop locked[0] at the 5th cycle -> return to WAIT_LOCK with retry_count unchanged; RELEASE only after 8 fresh consecutive all-locked cycles.
REQ-036 Assert reset for one cycle during RELEASE (domain_reset=2'b10) -> all outputs at REQ-029 values on the next edge; lock_loss_count=0.
